botoes_comando: RTL and testbench
=================================

BOTOES_COMANDO -- requirements
Module: botoes_comando

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clocks (20 ms at 50 MHz) before a key level is accepted.
REQ-002 Parameter REPEAT_CYCLES, default 25000000: hold interval for auto-repeat (used only under REQ-024).
REQ-003 Port clock  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port key_avanca_n  input  1  raw, asynchronous "advance" pushbutton; active-low.
REQ-006 Port key_volta_n  input  1  raw, asynchronous "back" pushbutton; active-low.
REQ-007 Port tick  input  1  one-clock consume strobe from the frequency divider; marks the cycle in which the downstream FSM samples entradas.
REQ-008 Port entradas  output  2  registered pending command: 00 none, 01 advance, 10 back, 11 blank.
REQ-009 Port pendente  output  1  registered; high while entradas != 00.
REQ-010 Port perdido  output  1  registered; one-clock pulse when a pending command is overwritten before being consumed.

Function
REQ-011 Each key SHALL pass through a 2-flop synchronizer before any other logic; the synchronized level is inverted to active-high "pressed".
REQ-012 Per key, a debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive clocks; any cycle of agreement SHALL zero that key's counter.
REQ-013 A press event SHALL be a debounced 0->1 transition; releases generate no event.
REQ-014 Event encoding:
- advance only -> 01
- back only -> 10
- both events in the same cycle, or one key's event while the other key is debounced-pressed -> 11
REQ-015 A press event SHALL load its code into the pending register at the next clock edge.
REQ-016 Any event arriving while the register is non-zero SHALL replace it (last wins); perdido SHALL pulse in that same cycle.
REQ-017 entradas SHALL hold its value through the tick cycle and clear to 00 at the edge that ends a cycle with tick=1.
REQ-018 If tick and an event coincide, the event code SHALL win: entradas takes the new code, perdido stays low, and the old code counts as consumed.
REQ-019 tick with entradas=00 and no event SHALL have no effect.
REQ-020 Latency: raw key change -> entradas update = 2 (sync) + DEBOUNCE_CYCLES + 1 clocks.
REQ-021 Counters SHALL be $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1) bits wide and saturate, never wrap.

Reset
REQ-022 While reset=1, asynchronously: synchronizers, debounced levels and counters = 0 (released); entradas = 00; pendente = 0; perdido = 0.
REQ-023 A key held through reset release SHALL produce a press event once its debounce completes; this is a defined behaviour, not an error.

Configuration
REQ-024 Macro BOTOES_AUTOREPEAT_EN:
- defined: a single key held debounced-pressed SHALL re-issue its code every REPEAT_CYCLES clocks after the initial event, following REQ-016/REQ-018; the repeat counter clears on release; both keys held SHALL NOT repeat 11.
- undefined: no repeat logic exists, and one press yields exactly one event.

Structure
REQ-025 Package botoes_pkg SHALL hold:
- command codes CMD_NENHUM = 2'b00, CMD_AVANCA = 2'b01, CMD_VOLTA = 2'b10, CMD_APAGAR = 2'b11
- default DEBOUNCE_CYCLES/REPEAT_CYCLES constants.
REQ-026 Sub-module debounce_tecla (synchronizer + debounce + edge detect; outputs nivel, evento) SHALL be instantiated once per key.

Verification (DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32 for simulation)
REQ-027 Advance press held 20 clocks -> entradas=01 at clock 11 after the press; tick 5 clocks later -> entradas=00 the next clock; perdido never pulses.
REQ-028 Bouncy advance press (toggle every 3 clocks for 30 clocks, then held low) -> exactly one 01 event, 11 clocks after the final edge.
REQ-029 Back pressed, advance pressed 20 clocks later while back still held -> 10, then 11; perdido pulses once when 11 overwrites 10.
REQ-030 Event coincides with tick while 01 pending, new back press -> entradas=10 after the edge, perdido=0.
REQ-031 Reset asserted with 10 pending and a debounce half complete -> entradas=00 immediately (asynchronous); no event for 8 clocks after release.
REQ-032 With BOTOES_AUTOREPEAT_EN, advance held 100 clocks -> events at t, t+32, t+64, t+96; without the macro -> single event.

Source files
------------

// File: rtl/botoes_pkg.sv
// Shared command codes, default timing constants and counter sizing for the
// two-key command front end (botoes_comando).
package botoes_pkg;

    typedef enum logic [1:0] {
        CMD_NENHUM = 2'b00,
        CMD_AVANCA = 2'b01,
        CMD_VOLTA  = 2'b10,
        CMD_APAGAR = 2'b11
    } cmd_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

    // Counter width large enough to hold the larger of two interval lengths.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/debounce_tecla.sv
// One pushbutton: 2-flop synchronizer, stable-level debounce and press-edge
// detection. nivel is the debounced active-high level, evento its 0->1 edge.
module debounce_tecla
    import botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic tecla_n,
    output logic nivel,
    output logic evento
);

    // Inverted ahead of the first flop so a cleared synchronizer reads "released".
    logic [1:0]       sync_q;
    logic             nivel_q;
    logic             nivel_ant_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            nivel_q     <= 1'b0;
            nivel_ant_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_q      <= {sync_q[0], ~tecla_n};
            nivel_ant_q <= nivel_q;
            if (sync_q[1] != nivel_q) begin
                if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    nivel_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign nivel  = nivel_q;
    assign evento = nivel_q & ~nivel_ant_q;

endmodule

// File: rtl/botoes_comando.sv
// Two-key command front end: debounced press events become a pending command
// consumed by tick. Optional auto-repeat under macro BOTOES_AUTOREPEAT_EN.
module botoes_comando
    import botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_avanca_n,
    input  logic       key_volta_n,
    input  logic       tick,
    output logic [1:0] entradas,
    output logic       pendente,
    output logic       perdido
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);

    logic lv_a, lv_v, ev_a, ev_v;
    logic ev_valid;
    cmd_t ev_cmd;
    cmd_t ent_q, ent_d;
    logic pend_q, perd_q, perd_d;

    debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_avanca (
        .clock  (clock),
        .reset  (reset),
        .tecla_n(key_avanca_n),
        .nivel  (lv_a),
        .evento (ev_a)
    );

    debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_volta (
        .clock  (clock),
        .reset  (reset),
        .tecla_n(key_volta_n),
        .nivel  (lv_v),
        .evento (ev_v)
    );

`ifdef BOTOES_AUTOREPEAT_EN
    logic             so_um;
    logic             rep_hit;
    logic [CNT_W-1:0] rep_q, rep_d;

    assign so_um   = lv_a ^ lv_v;
    assign rep_hit = so_um && (rep_q == CNT_W'(REPEAT_CYCLES));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`endif

    // An event implies its own key's level is high, so both levels high means 11.
    always_comb begin
        ev_valid = ev_a | ev_v;
        ev_cmd   = CMD_NENHUM;
        if (ev_valid) begin
            if (lv_a && lv_v) ev_cmd = CMD_APAGAR;
            else if (ev_a)    ev_cmd = CMD_AVANCA;
            else              ev_cmd = CMD_VOLTA;
        end
`ifdef BOTOES_AUTOREPEAT_EN
        rep_d = rep_q;
        if (!so_um)                   rep_d = '0;
        else if (ev_valid || rep_hit) rep_d = CNT_W'(1);
        else if (rep_q != '1)         rep_d = rep_q + CNT_W'(1);
        if (!ev_valid && rep_hit) begin
            ev_valid = 1'b1;
            ev_cmd   = lv_a ? CMD_AVANCA : CMD_VOLTA;
        end
`endif
    end

    // A new event beats a coinciding tick; only an unconsumed overwrite is lost.
    always_comb begin
        ent_d  = ent_q;
        perd_d = 1'b0;
        if (ev_valid) begin
            ent_d  = ev_cmd;
            perd_d = (ent_q != CMD_NENHUM) && !tick;
        end else if (tick) begin
            ent_d = CMD_NENHUM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_q  <= CMD_NENHUM;
            pend_q <= 1'b0;
            perd_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            pend_q <= (ent_d != CMD_NENHUM);
            perd_q <= perd_d;
        end
    end

    assign entradas = ent_q;
    assign pendente = pend_q;
    assign perdido  = perd_q;

endmodule

// File: tb/tb_botoes_comando.sv
// Directed bench for botoes_comando with short debounce/repeat intervals.
module tb_botoes_comando;

    logic       clock;
    logic       reset;
    logic       key_avanca_n;
    logic       key_volta_n;
    logic       tick;
    logic [1:0] entradas;
    logic       pendente;
    logic       perdido;

    int n_checks = 0;
    int n_errors = 0;
    int perd_cnt = 0;

    botoes_comando #(.DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .key_avanca_n(key_avanca_n),
        .key_volta_n (key_volta_n),
        .tick        (tick),
        .entradas    (entradas),
        .pendente    (pendente),
        .perdido     (perdido)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (perdido === 1'b1) perd_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Steps n clocks, counting samples where a command is pending.
    task automatic step_count(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (entradas != 2'b00) hits++;
        end
    endtask

    task automatic consume;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        int p0;
        int h;
        int acc;
        int exp_rep;

        reset        = 1'b1;
        key_avanca_n = 1'b1;
        key_volta_n  = 1'b1;
        tick         = 1'b0;
        #1;
        check_eq("reset_async_entradas", 32'(entradas), 32'h0);
        step(2);
        check_eq("reset_entradas", 32'(entradas), 32'h0);
        check_eq("reset_pendente", 32'(pendente), 32'h0);
        check_eq("reset_perdido", 32'(perdido), 32'h0);
        reset = 1'b0;
        step(3);

        // Clean advance press: 01 on clock 11, tick clears it.
        p0 = perd_cnt;
        key_avanca_n = 1'b0;
        step(10);
        check_eq("t1_before_latency", 32'(entradas), 32'h0);
        step(1);
        check_eq("t1_advance", 32'(entradas), 32'h1);
        check_eq("t1_pendente", 32'(pendente), 32'h1);
        step(4);
        check_eq("t1_held", 32'(entradas), 32'h1);
        consume();
        check_eq("t1_consumed", 32'(entradas), 32'h0);
        check_eq("t1_pend_clear", 32'(pendente), 32'h0);
        step(4);
        key_avanca_n = 1'b1;
        step_count(16, h);
        check_eq("t1_release_no_event", 32'(h), 32'h0);
        check_eq("t1_no_perdido", 32'(perd_cnt - p0), 32'h0);

        // Bouncing advance key, then held: one event 11 clocks after the last edge.
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) key_avanca_n = ((c / 3) % 2 == 1);
            step_count(1, h);
            acc += h;
        end
        check_eq("t2_bounce_quiet", 32'(acc), 32'h0);
        key_avanca_n = 1'b0;
        step_count(10, h);
        check_eq("t2_before_latency", 32'(h), 32'h0);
        step(1);
        check_eq("t2_advance", 32'(entradas), 32'h1);
        consume();
        step(4);
        key_avanca_n = 1'b1;
        step_count(16, h);
        check_eq("t2_single_event", 32'(h), 32'h0);

        // Back, then advance while back held: 10 then 11 with one lost pulse.
        p0 = perd_cnt;
        key_volta_n = 1'b0;
        step(11);
        check_eq("t3_back", 32'(entradas), 32'h2);
        step(9);
        key_avanca_n = 1'b0;
        step(10);
        check_eq("t3_still_back", 32'(entradas), 32'h2);
        check_eq("t3_no_lost_yet", 32'(perd_cnt - p0), 32'h0);
        step(1);
        check_eq("t3_blank", 32'(entradas), 32'h3);
        check_eq("t3_perdido_pulse", 32'(perdido), 32'h1);
        step(1);
        check_eq("t3_perdido_one_clock", 32'(perdido), 32'h0);
        key_avanca_n = 1'b1;
        key_volta_n  = 1'b1;
        step(16);
        check_eq("t3_blank_held", 32'(entradas), 32'h3);
        check_eq("t3_lost_once", 32'(perd_cnt - p0), 32'h1);
        consume();
        check_eq("t3_consumed", 32'(entradas), 32'h0);

        // Tick coincides with a back event while 01 is pending: event wins.
        key_avanca_n = 1'b0;
        step(11);
        check_eq("t4_advance", 32'(entradas), 32'h1);
        key_avanca_n = 1'b1;
        step(16);
        check_eq("t4_pending_kept", 32'(entradas), 32'h1);
        p0 = perd_cnt;
        key_volta_n = 1'b0;
        step(10);
        check_eq("t4_before_event", 32'(entradas), 32'h1);
        consume();
        check_eq("t4_event_wins", 32'(entradas), 32'h2);
        check_eq("t4_perdido_low", 32'(perdido), 32'h0);
        step(1);
        check_eq("t4_new_pending", 32'(entradas), 32'h2);
        check_eq("t4_no_lost", 32'(perd_cnt - p0), 32'h0);
        key_volta_n = 1'b1;
        step(16);
        consume();
        check_eq("t4_cleared", 32'(entradas), 32'h0);

        // Reset mid-debounce with 10 pending; held key yields an event later.
        key_volta_n = 1'b0;
        step(11);
        check_eq("t5_back", 32'(entradas), 32'h2);
        key_volta_n = 1'b1;
        step(16);
        key_avanca_n = 1'b0;
        step(6);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_async_clear", 32'(entradas), 32'h0);
        check_eq("t5_async_pend", 32'(pendente), 32'h0);
        step(2);
        reset = 1'b0;
        step_count(10, h);
        check_eq("t5_no_event_after_release", 32'(h), 32'h0);
        step(1);
        check_eq("t5_held_through_reset", 32'(entradas), 32'h1);
        consume();
        key_avanca_n = 1'b1;
        step(16);

        // Advance held 100 clocks with tick always high.
        p0 = perd_cnt;
        tick = 1'b1;
        key_avanca_n = 1'b0;
        step_count(100, acc);
        key_avanca_n = 1'b1;
        step_count(20, h);
        acc += h;
        tick = 1'b0;
`ifdef BOTOES_AUTOREPEAT_EN
        exp_rep = 4;
`else
        exp_rep = 1;
`endif
        check_eq("t6_event_count", 32'(acc), 32'(exp_rep));
        check_eq("t6_no_lost", 32'(perd_cnt - p0), 32'h0);
        check_eq("t6_idle", 32'(entradas), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
